// File: rtl/pa_ram_banked.sv
// pa_ram_banked: banked weight buffer for the NN accelerator operand feed.
// A word-wide write port fills one bank at a time. A read port returns one lane from every bank
// at a common word/lane offset through a 2-stage registered pipeline. With PINGPONG=1 the loader
// writes one buffer while the PE array reads the other; a drain-then-swap FSM exchanges them.
module pa_ram_banked #(
   parameter int unsigned NUM_BANKS  = 16,
   parameter int unsigned BANK_WORDS = 512,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned LANES      = 4,
   parameter int unsigned PINGPONG   = 1,
   localparam int unsigned BA = $clog2(NUM_BANKS),
   localparam int unsigned WA = $clog2(BANK_WORDS),
   localparam int unsigned LA = $clog2(LANES)
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            wr_valid_i,
   output logic                            wr_ready_o,
   input  logic [BA+WA-1:0]                wr_addr_i,
   input  logic [LANES*DATA_WIDTH-1:0]     wr_data_i,
   input  logic                            rd_valid_i,
   output logic                            rd_ready_o,
   input  logic [WA+LA-1:0]                rd_addr_i,
   output logic                            rd_data_valid_o,
   output logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data_o,
   input  logic                            swap_req_i,
   output logic                            swap_ack_o,
   output logic                            wr_buf_o
);

   localparam int unsigned WordW = LANES * DATA_WIDTH;
   localparam int unsigned Depth = ((PINGPONG != 0) ? 2 : 1) * BANK_WORDS;
   localparam int unsigned IdxW  = $clog2(Depth);

   typedef enum logic [1:0] {StIdle, StDrain, StSwap} state_e;

   state_e                         state_q, state_d;
   logic                           wr_buf_q, wr_buf_d;
   logic                           ports_open;
   logic                           swap_ack;
   logic                           wr_fire, rd_fire;
   logic [BA-1:0]                  wr_bank;
   logic [WA-1:0]                  wr_word;
   logic [WA-1:0]                  rd_word;
   logic [LA-1:0]                  rd_lane;
   logic                           rd_buf;
   logic [IdxW-1:0]                wr_idx, rd_idx;
   logic [NUM_BANKS-1:0]           bank_en;
   logic                           s1_valid_q;
   logic [LA-1:0]                  s1_lane_q;
   logic [DATA_WIDTH-1:0]          lane_sel [NUM_BANKS];
   logic                           rd_valid_q;
   logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data_q, rd_data_d;

   // Address fields
   assign wr_bank = wr_addr_i[BA+WA-1:WA];
   assign wr_word = wr_addr_i[WA-1:0];
   assign rd_word = rd_addr_i[WA+LA-1:LA];
   assign rd_lane = rd_addr_i[LA-1:0];

   // Readers always see the buffer the loader is not filling; single-buffer mode shares buffer 0.
   assign rd_buf = (PINGPONG != 0) ? ~wr_buf_q : 1'b0;

   // The cast drops the buffer bit when only one buffer exists.
   assign wr_idx = IdxW'({wr_buf_q, wr_word});
   assign rd_idx = IdxW'({rd_buf, rd_word});

   // Ports stay closed while reset is asserted so nothing is accepted during reset.
   assign ports_open = (state_q == StIdle) && !rst_i;
   assign wr_ready_o = ports_open;
   assign rd_ready_o = ports_open;
   assign wr_fire    = wr_valid_i && ports_open;
   assign rd_fire    = rd_valid_i && ports_open;

   // One-hot bank write enable
   always_comb begin
      bank_en = '0;
      if (wr_fire) begin
         bank_en[wr_bank] = 1'b1;
      end
   end

   // FSM next state and swap strobe.
   // DRAIN leaves once stage 1 is empty: nothing enters while draining, so stage 2 is empty too
   // by the time SWAP is active, and the buffer flip is visible together with swap_ack.
   always_comb begin
      state_d  = state_q;
      wr_buf_d = wr_buf_q;
      swap_ack = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (swap_req_i) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (!s1_valid_q) begin
               state_d = StSwap;
               if (PINGPONG != 0) begin
                  wr_buf_d = ~wr_buf_q;
               end
            end
         end
         StSwap: begin
            swap_ack = 1'b1;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM state and buffer select registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         wr_buf_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_buf_q <= wr_buf_d;
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [WordW-1:0] mem_q [Depth];
      logic [WordW-1:0] word_q;

      // Bank storage; contents survive reset
      always_ff @(posedge clk_i) begin
         if (bank_en[b]) begin
            mem_q[wr_idx] <= wr_data_i;
         end
      end

      // Read stage 1: capture the addressed word (old data on a same-cycle write)
      always_ff @(posedge clk_i) begin
         if (rd_fire) begin
            word_q <= mem_q[rd_idx];
         end
      end

      assign lane_sel[b] = word_q[s1_lane_q*DATA_WIDTH +: DATA_WIDTH];
   end

   // Gather the selected lane of every bank into the output row
   always_comb begin
      rd_data_d = '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         rd_data_d[b*DATA_WIDTH +: DATA_WIDTH] = lane_sel[b];
      end
   end

   // Read pipeline control and stage 2 output register; rd_data holds when idle
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         s1_lane_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         s1_valid_q <= rd_fire;
         if (rd_fire) begin
            s1_lane_q <= rd_lane;
         end
         rd_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            rd_data_q <= rd_data_d;
         end
      end
   end

   assign rd_data_valid_o = rd_valid_q;
   assign rd_data_o       = rd_data_q;
   assign swap_ack_o      = swap_ack;
   assign wr_buf_o        = wr_buf_q;

endmodule

// File: tb/tb_pa_ram_banked.sv
// Bench for pa_ram_banked: one ping-pong instance and one single-buffer instance, with a
// reference memory model feeding per-instance expected-row queues checked at the read output.
module tb_pa_ram_banked;

   localparam int NB = 16;
   localparam int BW = 512;
   localparam int DW = 8;
   localparam int LN = 4;
   localparam int BA = 4;
   localparam int WA = 9;
   localparam int LA = 2;
   localparam int RW = NB * DW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Ping-pong instance
   logic              wr_valid, wr_ready, rd_valid, rd_ready, rd_dv, swap_req, swap_ack, wr_buf;
   logic [BA+WA-1:0]  wr_addr;
   logic [LN*DW-1:0]  wr_data;
   logic [WA+LA-1:0]  rd_addr;
   logic [RW-1:0]     rd_data;
   // Single-buffer instance
   logic              wr_valid0, wr_ready0, rd_valid0, rd_ready0, rd_dv0, swap_req0, swap_ack0;
   logic              wr_buf0;
   logic [BA+WA-1:0]  wr_addr0;
   logic [LN*DW-1:0]  wr_data0;
   logic [WA+LA-1:0]  rd_addr0;
   logic [RW-1:0]     rd_data0;

   int n_checks = 0;
   int n_errors = 0;

   bit [31:0]   mdl  [2][NB][BW];
   bit [31:0]   mdl0 [NB][BW];
   int          mwbuf;
   logic [RW-1:0] exp_q[$];
   logic [RW-1:0] exp0_q[$];
   logic [RW-1:0] e1, e0;
   int          run_len = 0;
   int          last_run = 0;

   pa_ram_banked #(.PINGPONG(1)) u_dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .wr_valid_i     (wr_valid),
      .wr_ready_o     (wr_ready),
      .wr_addr_i      (wr_addr),
      .wr_data_i      (wr_data),
      .rd_valid_i     (rd_valid),
      .rd_ready_o     (rd_ready),
      .rd_addr_i      (rd_addr),
      .rd_data_valid_o(rd_dv),
      .rd_data_o      (rd_data),
      .swap_req_i     (swap_req),
      .swap_ack_o     (swap_ack),
      .wr_buf_o       (wr_buf)
   );

   pa_ram_banked #(.PINGPONG(0)) u_dut0 (
      .clk_i          (clk),
      .rst_i          (rst),
      .wr_valid_i     (wr_valid0),
      .wr_ready_o     (wr_ready0),
      .wr_addr_i      (wr_addr0),
      .wr_data_i      (wr_data0),
      .rd_valid_i     (rd_valid0),
      .rd_ready_o     (rd_ready0),
      .rd_addr_i      (rd_addr0),
      .rd_data_valid_o(rd_dv0),
      .rd_data_o      (rd_data0),
      .swap_req_i     (swap_req0),
      .swap_ack_o     (swap_ack0),
      .wr_buf_o       (wr_buf0)
   );

   task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [RW-1:0] exp_row(input bit pp, input int rbuf, input int word,
                                             input int lane);
      logic [RW-1:0] r;
      logic [31:0]   w;
      r = '0;
      for (int b = 0; b < NB; b++) begin
         w = pp ? mdl[rbuf][b][word] : mdl0[b][word];
         r[b*DW +: DW] = w[lane*DW +: DW];
      end
      return r;
   endfunction

   // Scoreboard for the ping-pong instance, plus run length of consecutive valid cycles
   always @(negedge clk) begin
      if (rd_dv) begin
         run_len = run_len + 1;
         if (exp_q.size() == 0) begin
            check("rd_unexpected", RW'(1), RW'(0));
         end else begin
            e1 = exp_q.pop_front();
            check("rd_data", rd_data, e1);
         end
      end else begin
         if (run_len != 0) last_run = run_len;
         run_len = 0;
      end
   end

   // Scoreboard for the single-buffer instance
   always @(negedge clk) begin
      if (rd_dv0) begin
         if (exp0_q.size() == 0) begin
            check("rd0_unexpected", RW'(1), RW'(0));
         end else begin
            e0 = exp0_q.pop_front();
            check("rd0_data", rd_data0, e0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      wr_valid  = 1'b0;
      rd_valid  = 1'b0;
      wr_valid0 = 1'b0;
      rd_valid0 = 1'b0;
   endtask

   task automatic drv_wr(input int bank, input int word, input logic [31:0] data);
      wr_valid = 1'b1;
      wr_addr  = (BA+WA)'(bank * BW + word);
      wr_data  = data;
      mdl[mwbuf][bank][word] = data;
   endtask

   task automatic drv_rd(input int word, input int lane);
      rd_valid = 1'b1;
      rd_addr  = (WA+LA)'(word * LN + lane);
      exp_q.push_back(exp_row(1'b1, 1 - mwbuf, word, lane));
   endtask

   task automatic drv0_wr(input int bank, input int word, input logic [31:0] data);
      wr_valid0 = 1'b1;
      wr_addr0  = (BA+WA)'(bank * BW + word);
      wr_data0  = data;
      mdl0[bank][word] = data;
   endtask

   task automatic drv0_rd(input int word, input int lane);
      rd_valid0 = 1'b1;
      rd_addr0  = (WA+LA)'(word * LN + lane);
      exp0_q.push_back(exp_row(1'b0, 0, word, lane));
   endtask

   task automatic chk_reset(input string t);
      check({t, "_wr_ready"}, RW'(wr_ready), RW'(0));
      check({t, "_rd_ready"}, RW'(rd_ready), RW'(0));
      check({t, "_rd_dv"}, RW'(rd_dv), RW'(0));
      check({t, "_rd_data"}, rd_data, RW'(0));
      check({t, "_swap_ack"}, RW'(swap_ack), RW'(0));
      check({t, "_wr_buf"}, RW'(wr_buf), RW'(0));
   endtask

   task automatic do_swap(input string tag);
      bit seen;
      seen = 1'b0;
      swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (swap_ack) seen = 1'b1;
      end
      check({tag, "_ack"}, RW'(seen), RW'(1));
      mwbuf = 1 - mwbuf;
      check({tag, "_wr_buf"}, RW'(wr_buf), RW'(mwbuf));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      bit seen0;
      rst = 1'b1;
      wr_valid = 0; rd_valid = 0; swap_req = 0; wr_addr = '0; wr_data = '0; rd_addr = '0;
      wr_valid0 = 0; rd_valid0 = 0; swap_req0 = 0; wr_addr0 = '0; wr_data0 = '0; rd_addr0 = '0;
      mwbuf = 0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk_reset("rst1");
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("idle_wr_ready", RW'(wr_ready), RW'(1));
      check("idle_rd_ready", RW'(rd_ready), RW'(1));
      @(posedge clk);
      #1;

      // Fill buffer 0: word 5 zero except bank 3, word 7 lane pattern, word 9 = 0x55
      for (int b = 0; b < NB; b++) begin
         drv_wr(b, 5, (b == 3) ? 32'h4433_2211 : 32'h0);
         step();
      end
      for (int b = 0; b < NB; b++) begin
         drv_wr(b, 7, {8'(16 * (b + 3)), 8'(16 * (b + 2)), 8'(16 * (b + 1)), 8'(16 * b)});
         step();
      end
      for (int b = 0; b < NB; b++) begin
         drv_wr(b, 9, 32'h5555_5555);
         step();
      end
      do_swap("swap1");

      // Single read: exactly 2 cycles of latency
      drv_rd(5, 1);
      step();
      @(negedge clk);
      check("t1_lat1", RW'(rd_dv), RW'(0));
      @(negedge clk);
      check("t1_lat2", RW'(rd_dv), RW'(1));
      check("t1_bank3", RW'(rd_data[3*DW +: DW]), RW'(8'h22));
      check("t1_bank0", RW'(rd_data[DW-1:0]), RW'(0));
      @(posedge clk);
      #1;

      // Back-to-back stream of 4 reads
      for (int k = 0; k < 4; k++) begin
         drv_rd(7, k);
         step();
      end
      repeat (4) @(negedge clk);
      check("t2_run", RW'(last_run), RW'(4));
      @(posedge clk);
      #1;

      // Concurrent fill of the write buffer while reading the read buffer
      for (int b = 0; b < NB; b++) begin
         drv_rd(9, b % LN);
         drv_wr(b, 9, 32'hAAAA_AAAA);
         step();
      end
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;

      // Swap requested with two reads in flight
      drv_rd(9, 0);
      step();
      drv_rd(9, 1);
      swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      @(negedge clk);
      check("t3_c1_wr_ready", RW'(wr_ready), RW'(0));
      check("t3_c1_rd_ready", RW'(rd_ready), RW'(0));
      check("t3_c1_dv", RW'(rd_dv), RW'(1));
      check("t3_old_data", RW'(rd_data[DW-1:0]), RW'(8'h55));
      @(negedge clk);
      check("t3_c2_rd_ready", RW'(rd_ready), RW'(0));
      check("t3_c2_dv", RW'(rd_dv), RW'(1));
      check("t3_c2_ack", RW'(swap_ack), RW'(0));
      @(negedge clk);
      check("t3_c3_ack", RW'(swap_ack), RW'(1));
      check("t3_c3_dv", RW'(rd_dv), RW'(0));
      check("t3_c3_wr_ready", RW'(wr_ready), RW'(0));
      mwbuf = 1 - mwbuf;
      check("t3_wr_buf", RW'(wr_buf), RW'(mwbuf));
      @(negedge clk);
      check("t3_c4_ack", RW'(swap_ack), RW'(0));
      check("t3_c4_rd_ready", RW'(rd_ready), RW'(1));
      check("t3_c4_wr_ready", RW'(wr_ready), RW'(1));
      @(posedge clk);
      #1;

      // Reads now target the freshly filled buffer
      drv_rd(9, 2);
      step();
      @(negedge clk);
      @(negedge clk);
      check("t5_new_data", RW'(rd_data[DW-1:0]), RW'(8'hAA));
      @(posedge clk);
      #1;

      // Single-buffer: same-cycle write/read returns old data, next read returns new
      for (int b = 0; b < NB; b++) begin
         drv0_wr(b, 2, 32'h1111_1111);
         step();
      end
      drv0_rd(2, 0);
      drv0_wr(5, 2, 32'hDEAD_BEEF);
      step();
      drv0_rd(2, 0);
      step();
      @(negedge clk);
      check("t6_old", RW'(rd_data0[5*DW +: DW]), RW'(8'h11));
      @(negedge clk);
      check("t6_new", RW'(rd_data0[5*DW +: DW]), RW'(8'hEF));
      @(posedge clk);
      #1;

      // Single-buffer swap acknowledges but keeps buffer 0
      swap_req0 = 1'b1;
      step();
      swap_req0 = 1'b0;
      seen0 = 1'b0;
      for (int i = 0; i < 10 && !seen0; i++) begin
         @(negedge clk);
         if (swap_ack0) seen0 = 1'b1;
      end
      check("t7_ack0", RW'(seen0), RW'(1));
      check("t7_wr_buf0", RW'(wr_buf0), RW'(0));
      @(posedge clk);
      #1;

      // Reset while draining with a read in flight
      drv_rd(5, 1);
      swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      exp0_q.delete();
      mwbuf = 0;
      @(negedge clk);
      chk_reset("rst2");
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst2_rel_wr_ready", RW'(wr_ready), RW'(1));
      check("rst2_rel_rd_ready", RW'(rd_ready), RW'(1));
      check("rst2_rel_dv", RW'(rd_dv), RW'(0));
      check("rst2_rel_wr_buf", RW'(wr_buf), RW'(0));

      repeat (5) @(negedge clk);
      check("sb_empty", RW'(exp_q.size()), RW'(0));
      check("sb0_empty", RW'(exp0_q.size()), RW'(0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
